// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package Pipe_Buf_Reg_PKG;

  // Debug-port transaction phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  // Debug accesses are always full-word.
  localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter: counts enabled cycles and holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  // Count enabled cycles, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the MEM stage and a debug port. The CPU has
// priority; a pending debug access is forced through after STARVE_MAX waits,
// stalling the pipeline for that single cycle.
module dmem_arbiter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [15:0]           stall_count
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

  arb_state_e            state_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic                  hold_we_q;
  logic [DM_ADDRESS-1:0] hold_addr_q;
  logic [DATA_W-1:0]     hold_wdata_q;
  logic [DATA_W-1:0]     dbg_rdata_q;

  logic cpu_req;
  logic dbg_grant;

  // Debug transaction FSM, holding registers and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dbg_req) begin
            hold_we_q    <= dbg_we;
            hold_addr_q  <= dbg_addr;
            hold_wdata_q <= dbg_wdata;
            wait_cnt_q   <= '0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (dbg_grant) begin
            if (!hold_we_q) dbg_rdata_q <= mem_rdata;
            state_q <= ACK;
          end else if (wait_cnt_q != StarveMax) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory-port mux: CPU pass-through unless the debug port holds the grant.
  // Reset suppresses every memory enable and the ack so an aborted
  // transaction leaves no trace.
  always_comb begin
    cpu_req   = cpu_rd | cpu_wr;
    dbg_grant = (state_q == WAIT) && !reset && (!cpu_req || (wait_cnt_q == StarveMax));
    mem_rd    = cpu_rd & ~reset;
    mem_wr    = cpu_wr & ~reset;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_func3 = cpu_func3;
    cpu_rdata = mem_rdata;
    cpu_stall = 1'b0;
    if (dbg_grant) begin
      mem_rd    = ~hold_we_q;
      mem_wr    = hold_we_q;
      mem_addr  = hold_addr_q;
      mem_wdata = hold_wdata_q;
      mem_func3 = FUNC3_WORD;
      cpu_rdata = '0;
      cpu_stall = cpu_req;
    end
    dbg_ack   = (state_q == ACK) && !reset;
    dbg_rdata = dbg_rdata_q;
  end

  sat_counter #(
    .Width (16)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (cpu_stall),
    .count_o (stall_count)
  );

endmodule
